mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-side consumer of the EXE-stage register outputs.
- Takes mem_r_en/mem_w_en, alu_result (byte address) and val_rm (store data), and runs each 32-bit access as two 16-bit transactions on an external SRAM.
- Drives freeze back to the pipeline registers until the access completes, then presents load data to the MEM stage register.

Parameters:
- WAIT_CYCLES, 2, cycles each 16-bit half-access is held on the SRAM bus; legal values are 1 or more.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- SRAM_AW, 18, SRAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_r_en  in  1  load request, held by upstream while freeze=1.
- mem_w_en  in  1  store request, held by upstream while freeze=1.
- alu_result  in  32  byte address.
- val_rm  in  32  store data.
- rdata  out  32  load result, valid while ready=1.
- ready  out  1  access completes this cycle.
- freeze  out  1  stall request to pipeline registers.
- sram_addr  out  SRAM_AW  SRAM halfword address.
- sram_wdata  out  16  SRAM write data.
- sram_rdata  in  16  SRAM read data, valid in the same cycle sram_oe_n=0.
- sram_we_n  out  1  SRAM write strobe, active low.
- sram_oe_n  out  1  SRAM output enable, active low.

Behaviour:
- Reset is synchronous and active-high. One clock, clk. Reset values:
  - state=IDLE, counter=0
  - rdata=0, ready=0
  - sram_addr=0, sram_wdata=0
  - sram_we_n=1, sram_oe_n=1
- req = mem_r_en | mem_w_en.
- freeze = req & ~ready. This is combinational and is 0 in IDLE with no request.
- Address mapping:
  - word = (alu_result - BASE_ADDR) >> 2, computed with 32-bit wraparound subtraction.
  - lo halfword address = {word[SRAM_AW-2:0], 1'b0}; hi halfword address = {word[SRAM_AW-2:0], 1'b1}.
  - Upper bits are silently truncated.
- IDLE:
  - If mem_w_en=1, latch the address and val_rm, then go to WR_LO.
  - Else if mem_r_en=1, latch the address, then go to RD_LO.
  - If both are set, the write wins and no read is done.
- WR_LO / WR_HI:
  - Drive sram_addr lo/hi, sram_wdata = val_rm[15:0] / val_rm[31:16], sram_we_n=0, for exactly WAIT_CYCLES cycles each.
  - WR_LO goes to WR_HI, WR_HI goes to DONE.
- RD_LO / RD_HI:
  - Drive sram_addr lo/hi with sram_oe_n=0 for WAIT_CYCLES cycles each.
  - Capture sram_rdata on the last cycle of each phase into rdata[15:0] / rdata[31:16].
  - RD_LO goes to RD_HI, RD_HI goes to DONE.
- DONE:
  - ready=1 for exactly one cycle, so freeze=0 and the pipeline advances.
  - Next state is IDLE unconditionally.
  - A request present in the following cycle is a new instruction.
- Timing: request seen in cycle 0, freeze high in cycles 0..2*WAIT_CYCLES, ready in cycle 2*WAIT_CYCLES+1.
- Outside DONE, ready=0. rdata holds its last value and is only updated by reads.
- sram_we_n and sram_oe_n are never both 0. Both are 1 in IDLE and DONE.
- Reset asserted mid-access aborts the access: the next cycle is IDLE with reset values, and no further SRAM strobe occurs.
- A request that drops mid-access (protocol violation) is ignored; the access still completes.

Optional Feature:
- Macro: MEM_RDBUF_EN.
- When defined, a one-entry read buffer holds {valid, word, data}.
  - Read hit (valid & word match) in IDLE: go straight to DONE with rdata = buffered data. freeze is high for 1 cycle and ready comes in cycle 1.
  - A read miss fills the buffer on completion.
  - A write to the same word updates the buffered data.
  - Reset clears valid.
- When not defined, every read performs the full SRAM sequence.

Decomposition:
- Package mem_ctrl_pkg holds:
  - the state enum {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE}
  - the BASE_ADDR default and the halfword select constants LO=0, HI=1
- Sub-module mem_wait_counter:
  - loadable down-counter of width clog2(WAIT_CYCLES+1)
  - outputs phase_last when the count is 1
  - reset synchronously on rst or on phase entry

Test Plan:
- Write, WAIT_CYCLES=2: mem_w_en=1, alu_result=1028, val_rm=0xDEADBEEF ->
  - sram_addr=2 with wdata=0xBEEF and we_n=0 in cycles 1-2
  - sram_addr=3 with wdata=0xDEAD in cycles 3-4
  - ready=1 in cycle 5; freeze high in cycles 0-4
- Read back: mem_r_en=1, alu_result=1028, SRAM model returns 0xBEEF at address 2 and 0xDEAD at address 3 -> rdata=0xDEADBEEF with ready=1 in cycle 5; oe_n=0 only in cycles 1-4.
- Both enables set: mem_r_en=mem_w_en=1, alu_result=1032, val_rm=0x12345678 -> write to addresses 4 and 5 occurs; oe_n is never 0.
- Reset mid-write: assert rst in cycle 2 of a write -> cycle 3 has we_n=1, freeze=0 with the request removed, and state IDLE; address 5 is never written.
- No request: hold mem_r_en=mem_w_en=0 for 10 cycles -> freeze=0, we_n=oe_n=1, sram_addr stays 0.
- With MEM_RDBUF_EN:
  - Read 1028 twice: second read gives ready in cycle 1 and no SRAM strobes.
  - Then write 0x0 to 1028 and read: rdata=0x00000000 from the buffer.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_ctrl_pkg                                                         |
// | Shared state encoding and constants for the SRAM access controller.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t WR_LO = 3'd1;
  localparam state_t WR_HI = 3'd2;
  localparam state_t RD_LO = 3'd3;
  localparam state_t RD_HI = 3'd4;
  localparam state_t DONE  = 3'd5;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_wait_counter                                                     |
// | Loadable down-counter timing one SRAM half-access phase.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_wait_counter #(
  parameter int WAIT_CYCLES = 2,
  localparam int CW = $clog2(WAIT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic phase_last
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Loading on phase entry makes the first phase cycle see the full count.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(WAIT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_last = (cnt_q == CW'(1));

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_ctrl                                                      |
// | Splits 32-bit loads/stores into two 16-bit SRAM accesses and stalls  |
// | the pipeline meanwhile. Optional read buffer: define MEM_RDBUF_EN.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        val_rm,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int WW = SRAM_AW - 1;

  state_t             state_q, state_d;
  logic [WW-1:0]      word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        sram_wdata_q, sram_wdata_d;
  logic               we_n_q, we_n_d;
  logic               oe_n_q, oe_n_d;

  logic [31:0]   w_offset;
  logic [WW-1:0] w_word;
  logic          w_unused_ok;
  logic          w_req;
  logic          w_ready;
  logic          w_load;
  logic          w_phase_last;
  logic          w_hit;
  logic [31:0]   w_hit_data;

  // Wraparound subtract, then drop byte offset and bits beyond the SRAM.
  assign w_offset    = alu_result - BASE_ADDR;
  assign w_word      = w_offset[SRAM_AW:2];
  assign w_unused_ok = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};

  assign w_req   = mem_r_en | mem_w_en;
  assign w_ready = (state_q == DONE);

`ifdef MEM_RDBUF_EN
  logic          buf_valid_q, buf_valid_d;
  logic [WW-1:0] buf_word_q, buf_word_d;
  logic [31:0]   buf_data_q, buf_data_d;

  assign w_hit      = mem_r_en & ~mem_w_en & buf_valid_q & (buf_word_q == w_word);
  assign w_hit_data = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_word_d  = buf_word_q;
    buf_data_d  = buf_data_q;
    if (state_q == IDLE && mem_w_en && buf_valid_q && buf_word_q == w_word) begin
      buf_data_d = val_rm;
    end
    if (state_q == RD_HI && w_phase_last) begin
      buf_valid_d = 1'b1;
      buf_word_d  = word_q;
      buf_data_d  = {sram_rdata, rdata_q[15:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_word_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_word_q  <= buf_word_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = 32'h0000_0000;
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_w_en) begin
          word_d  = w_word;
          wdata_d = val_rm;
          state_d = WR_LO;
        end else if (mem_r_en) begin
          word_d = w_word;
          if (w_hit) begin
            rdata_d = w_hit_data;
            state_d = DONE;
          end else begin
            state_d = RD_LO;
          end
        end
      end
      WR_LO: if (w_phase_last) state_d = WR_HI;
      WR_HI: if (w_phase_last) state_d = DONE;
      RD_LO: begin
        if (w_phase_last) begin
          rdata_d[15:0] = sram_rdata;
          state_d       = RD_HI;
        end
      end
      RD_HI: begin
        if (w_phase_last) begin
          rdata_d[31:16] = sram_rdata;
          state_d        = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are registered from the next state so strobes are glitch-free.
  always_comb begin
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    we_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    case (state_d)
      WR_LO: begin
        sram_addr_d  = {word_d, LO};
        sram_wdata_d = wdata_d[15:0];
        we_n_d       = 1'b0;
      end
      WR_HI: begin
        sram_addr_d  = {word_d, HI};
        sram_wdata_d = wdata_d[31:16];
        we_n_d       = 1'b0;
      end
      RD_LO: begin
        sram_addr_d = {word_d, LO};
        oe_n_d      = 1'b0;
      end
      RD_HI: begin
        sram_addr_d = {word_d, HI};
        oe_n_d      = 1'b0;
      end
      default: begin
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
      end
    endcase
  end

  assign w_load = (state_d != state_q) &&
                  (state_d == WR_LO || state_d == WR_HI ||
                   state_d == RD_LO || state_d == RD_HI);

  mem_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .phase_last (w_phase_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
    end
  end

  assign rdata      = rdata_q;
  assign ready      = w_ready;
  assign freeze     = w_req & ~w_ready;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign sram_we_n  = we_n_q;
  assign sram_oe_n  = oe_n_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_access_ctrl                                                   |
// | Directed and random accesses against an SRAM array and memory model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_access_ctrl;

  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          AW   = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_r_en, mem_w_en;
  logic [31:0]   alu_result, val_rm;
  logic [31:0]   rdata;
  logic          ready, freeze;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wdata, sram_rdata;
  logic          sram_we_n, sram_oe_n;

  mem_access_ctrl #(
    .WAIT_CYCLES (W),
    .BASE_ADDR   (BASE),
    .SRAM_AW     (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .alu_result (alu_result),
    .val_rm     (val_rm),
    .rdata      (rdata),
    .ready      (ready),
    .freeze     (freeze),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
  );

  always #5 clk = ~clk;

  // Physical SRAM driven by the DUT pins, and the expected memory image.
  bit [15:0] sram    [0:(1<<AW)-1];
  bit [15:0] ref_mem [0:(1<<AW)-1];

  assign sram_rdata = sram_oe_n ? 16'h0000 : sram[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n) sram[sram_addr] <= sram_wdata;
  end

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_rdata = 32'h0;
  bit          buf_valid = 1'b0;
  logic [16:0] buf_word = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts just after a rising edge; returns just after the edge following ready.
  task automatic access(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    logic [16:0] word;
    logic [17:0] lo, hi;
    logic [31:0] exp_rd;
    bit          is_wr, is_rd, hit, in_strobe, hi_phase;
    int          lat;
    word  = 17'((a - BASE) / 4);
    lo    = 18'(word * 2);
    hi    = lo + 18'd1;
    is_wr = w;
    is_rd = r && !w;
    hit   = 1'b0;
`ifdef MEM_RDBUF_EN
    hit = is_rd && buf_valid && (buf_word == word);
`endif
    lat    = hit ? 1 : 2 * W + 1;
    exp_rd = is_rd ? {ref_mem[hi], ref_mem[lo]} : last_rdata;
    mem_r_en   = r;
    mem_w_en   = w;
    alu_result = a;
    val_rm     = d;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      in_strobe = !hit && c >= 1 && c <= 2 * W;
      hi_phase  = c > W;
      check({tag, ":freeze"}, {31'b0, freeze}, {31'b0, c < lat});
      check({tag, ":ready"}, {31'b0, ready}, {31'b0, c == lat});
      check({tag, ":we_n"}, {31'b0, sram_we_n}, {31'b0, !(is_wr && in_strobe)});
      check({tag, ":oe_n"}, {31'b0, sram_oe_n}, {31'b0, !(is_rd && in_strobe)});
      if (in_strobe)
        check({tag, ":addr"}, {14'b0, sram_addr}, {14'b0, hi_phase ? hi : lo});
      if (in_strobe && is_wr)
        check({tag, ":wdata"}, {16'b0, sram_wdata}, {16'b0, hi_phase ? d[31:16] : d[15:0]});
      if (c == lat)
        check({tag, ":rdata"}, rdata, exp_rd);
      if (c < lat) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    if (is_wr) begin
      ref_mem[lo] = d[15:0];
      ref_mem[hi] = d[31:16];
    end
    if (is_rd) begin
      last_rdata = exp_rd;
      buf_valid  = 1'b1;
      buf_word   = word;
    end
  endtask

  initial begin
    bit          r, w;
    logic [31:0] a, d;
    rst        = 1'b1;
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b0;
    alu_result = 32'h0;
    val_rm     = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst:rdata", rdata, 32'h0);
    check("rst:ready", {31'b0, ready}, 32'h0);
    check("rst:freeze", {31'b0, freeze}, 32'h0);
    check("rst:addr", {14'b0, sram_addr}, 32'h0);
    check("rst:wdata", {16'b0, sram_wdata}, 32'h0);
    check("rst:we_n", {31'b0, sram_we_n}, 32'h1);
    check("rst:oe_n", {31'b0, sram_oe_n}, 32'h1);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle:freeze", {31'b0, freeze}, 32'h0);
      check("idle:we_n", {31'b0, sram_we_n}, 32'h1);
      check("idle:oe_n", {31'b0, sram_oe_n}, 32'h1);
      check("idle:addr", {14'b0, sram_addr}, 32'h0);
    end
    @(posedge clk); #1;

    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, "wr1028");
    check("wr1028:sram2", {16'b0, sram[2]}, 32'h0000BEEF);
    check("wr1028:sram3", {16'b0, sram[3]}, 32'h0000DEAD);
    access(1'b1, 1'b0, 32'd1028, 32'h0, "rd1028");
    check("rd1028:value", last_rdata, 32'hDEADBEEF);
    access(1'b1, 1'b1, 32'd1032, 32'h12345678, "both");
    check("both:sram4", {16'b0, sram[4]}, 32'h00005678);
    check("both:sram5", {16'b0, sram[5]}, 32'h00001234);

    // Abort a write to 1040 (halfwords 8/9) during its low phase.
    sram[9]    = 16'hA5A5;
    ref_mem[9] = 16'hA5A5;
    mem_w_en   = 1'b1;
    alu_result = 32'd1040;
    val_rm     = 32'hCAFEF00D;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort:c2_we_n", {31'b0, sram_we_n}, 32'h0);
    @(posedge clk); #1;
    rst      = 1'b0;
    mem_w_en = 1'b0;
    @(negedge clk);
    check("abort:we_n", {31'b0, sram_we_n}, 32'h1);
    check("abort:oe_n", {31'b0, sram_oe_n}, 32'h1);
    check("abort:freeze", {31'b0, freeze}, 32'h0);
    check("abort:ready", {31'b0, ready}, 32'h0);
    check("abort:rdata", rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("abort:sram9", {16'b0, sram[9]}, 32'h0000A5A5);
    ref_mem[8] = 16'hF00D;
    last_rdata = 32'h0;
    buf_valid  = 1'b0;
    access(1'b1, 1'b0, 32'd1040, 32'h0, "rd1040");

`ifdef MEM_RDBUF_EN
    access(1'b1, 1'b0, 32'd1028, 32'h0, "buf_miss");
    access(1'b1, 1'b0, 32'd1028, 32'h0, "buf_hit");
    access(1'b0, 1'b1, 32'd1028, 32'h0, "buf_wr");
    access(1'b1, 1'b0, 32'd1028, 32'h0, "buf_hit2");
    check("buf_hit2:value", last_rdata, 32'h0);
`endif

    for (int i = 0; i < 40; i++) begin
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      d = $urandom;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      access(r, w, a, d, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
